// File: rtl/id_entry_shift.sv
// BCD ID entry: three debounced buttons shift digits into a 16-nibble register.
// Clear beats back beats enter when events coincide.

module id_entry_debounce #(
  parameter logic [27:0] DB = 28'd1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_event
);
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  state_t      r_state, w_next;
  logic [27:0] r_cnt;
  logic        w_hit;

  assign w_hit = (r_cnt == DB - 28'd1);

  always_comb begin
    w_next  = r_state;
    o_event = 1'b0;
    case (r_state)
      RELEASED:     if (i_sync) w_next = PRESS_WAIT;
      PRESS_WAIT:   if (!i_sync) w_next = RELEASED;
                    else if (w_hit) begin
                      w_next  = PRESSED;
                      o_event = 1'b1;
                    end
      PRESSED:      if (!i_sync) w_next = RELEASE_WAIT;
      RELEASE_WAIT: if (i_sync) w_next = PRESSED;
                    else if (w_hit) w_next = RELEASED;
      default:      w_next = RELEASED;
    endcase
  end

  // Counter only runs while waiting for stability; any state change restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == PRESS_WAIT || r_state == RELEASE_WAIT)
        r_cnt <= r_cnt + 28'd1;
      else
        r_cnt <= '0;
    end
  end
endmodule

module id_entry_shift #(
  parameter logic [27:0] debounce_cycles = 28'd1_000_000
) (
  input  logic        sys_clk_in,
  input  logic        reset,
  input  logic [3:0]  digit_in,
  input  logic        btn_enter,
  input  logic        btn_back,
  input  logic        btn_clear,
  output logic [63:0] binary_out,
  output logic [4:0]  digit_count,
  output logic        full,
  output logic        accept_pulse,
  output logic        error_pulse
);
  localparam int NUM_BTN = 3;

  logic [NUM_BTN-1:0] w_btn_raw, r_btn_s1, r_btn_s2, w_evt;
  logic [3:0]         r_dig_s1, r_dig_s2;
  logic               w_ev_enter, w_ev_back, w_ev_clear;

  assign w_btn_raw = {btn_clear, btn_back, btn_enter};

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_dig_s1 <= digit_in;
      r_dig_s2 <= r_dig_s1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_db
      id_entry_debounce #(.DB(debounce_cycles)) u_db (
        .i_clk   (sys_clk_in),
        .i_rst   (reset),
        .i_sync  (r_btn_s2[g]),
        .o_event (w_evt[g])
      );
    end
  endgenerate

  assign w_ev_enter = w_evt[0];
  assign w_ev_back  = w_evt[1];
  assign w_ev_clear = w_evt[2];
  assign full       = (digit_count == 5'd16);

  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      binary_out   <= '0;
      digit_count  <= '0;
      accept_pulse <= 1'b0;
      error_pulse  <= 1'b0;
    end else begin
      accept_pulse <= 1'b0;
      error_pulse  <= 1'b0;
      if (w_ev_clear) begin
        binary_out   <= '0;
        digit_count  <= '0;
        accept_pulse <= 1'b1;
      end else if (w_ev_back) begin
        if (digit_count != 5'd0) begin
          binary_out   <= {4'h0, binary_out[63:4]};
          digit_count  <= digit_count - 5'd1;
          accept_pulse <= 1'b1;
        end else begin
          error_pulse  <= 1'b1;
        end
      end else if (w_ev_enter) begin
        if (r_dig_s2 <= 4'd9 && digit_count < 5'd16) begin
          binary_out   <= {binary_out[59:0], r_dig_s2};
          digit_count  <= digit_count + 5'd1;
          accept_pulse <= 1'b1;
        end else begin
          error_pulse  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_id_entry_shift.sv
// Bench for id_entry_shift: directed scenarios plus random commands against a digit-queue model.
module tb_id_entry_shift;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  digit_in;
  logic        btn_enter, btn_back, btn_clear;
  logic [63:0] binary_out;
  logic [4:0]  digit_count;
  logic        full, accept_pulse, error_pulse;

  int checks = 0, failures = 0;
  int acc_cnt = 0, err_cnt = 0, both_cnt = 0;
  int q[$];   // digits held, oldest first

  id_entry_shift #(.debounce_cycles(28'd4)) dut (
    .sys_clk_in   (clk),
    .reset        (reset),
    .digit_in     (digit_in),
    .btn_enter    (btn_enter),
    .btn_back     (btn_back),
    .btn_clear    (btn_clear),
    .binary_out   (binary_out),
    .digit_count  (digit_count),
    .full         (full),
    .accept_pulse (accept_pulse),
    .error_pulse  (error_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (accept_pulse) acc_cnt++;
    if (error_pulse) err_cnt++;
    if (accept_pulse && error_pulse) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_bin();
    logic [63:0] b = '0;
    foreach (q[i]) b = b * 64'd16 + 64'(q[i]);
    return b;
  endfunction

  // Applies one command (bitmask {clear,back,enter}) to the model.
  task automatic model_cmd(input logic [2:0] m, input int d, output int ea, output int ee);
    ea = 0; ee = 0;
    if (m[2]) begin q.delete(); ea = 1; end
    else if (m[1]) begin
      if (q.size() > 0) begin void'(q.pop_back()); ea = 1; end else ee = 1;
    end else if (m[0]) begin
      if (d <= 9 && q.size() < 16) begin q.push_back(d); ea = 1; end else ee = 1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_bin"}, binary_out, model_bin());
    chk({tag, "_cnt"}, 64'(digit_count), 64'(q.size()));
    chk({tag, "_full"}, 64'(full), 64'(q.size() == 16));
  endtask

  task automatic press(input logic [2:0] m, input logic [3:0] d, input string tag, input bit check);
    int a0, e0, ea, ee;
    a0 = acc_cnt; e0 = err_cnt;
    model_cmd(m, int'(d), ea, ee);
    digit_in = d;
    {btn_clear, btn_back, btn_enter} = m;
    repeat (12) @(negedge clk);
    {btn_clear, btn_back, btn_enter} = 3'b000;
    repeat (12) @(negedge clk);
    if (check) begin
      chk({tag, "_acc"}, 64'(acc_cnt - a0), 64'(ea));
      chk({tag, "_err"}, 64'(err_cnt - e0), 64'(ee));
      check_state(tag);
    end
  endtask

  initial begin
    int a0, n;
    logic [2:0] m;
    logic [3:0] d;
    reset = 1'b1; digit_in = '0;
    btn_enter = 1'b0; btn_back = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_acc", 64'(accept_pulse), 64'd0);
    chk("reset_err", 64'(error_pulse), 64'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Empty-entry rejections
    press(3'b010, 4'h0, "back_empty", 1'b1);
    press(3'b001, 4'hA, "enter_A", 1'b1);

    // 2,0,2,2
    press(3'b001, 4'h2, "e2a", 1'b0);
    press(3'b001, 4'h0, "e0", 1'b0);
    press(3'b001, 4'h2, "e2b", 1'b0);
    press(3'b001, 4'h2, "e2c", 1'b1);
    chk("id_2022", binary_out, 64'h2022);

    // Bouncy enter: sync high only 3 cycles each time
    a0 = acc_cnt;
    digit_in = 4'h7;
    for (int i = 0; i < 5; i++) begin
      btn_enter = 1'b1; repeat (3) @(negedge clk);
      btn_enter = 1'b0; repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_acc", 64'(acc_cnt - a0), 64'd0);
    check_state("bounce");

    // Fill to 16 then overflow
    press(3'b100, 4'h0, "clr_fill", 1'b1);
    for (int i = 0; i < 16; i++) press(3'b001, 4'h1, "fill", 1'b0);
    check_state("full16");
    chk("full_val", binary_out, 64'h1111_1111_1111_1111);
    press(3'b001, 4'h1, "enter17", 1'b1);

    // Clear beats simultaneous enter
    press(3'b100, 4'h0, "clr0", 1'b0);
    press(3'b001, 4'h1, "s1", 1'b0);
    press(3'b001, 4'h2, "s2", 1'b0);
    press(3'b001, 4'h3, "s3", 1'b1);
    chk("pre_123", binary_out, 64'h123);
    press(3'b101, 4'h4, "clr_enter", 1'b1);
    press(3'b010, 4'h0, "back_after_clr", 1'b1);
    press(3'b100, 4'h0, "clr_empty", 1'b1);

    // Held enter across reset
    a0 = acc_cnt;
    digit_in = 4'h5; btn_enter = 1'b1;
    repeat (12) @(negedge clk);
    chk("hold_first_acc", 64'(acc_cnt - a0), 64'd1);
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_state("in_reset");
      chk("in_reset_acc", 64'(accept_pulse), 64'd0);
    end
    a0 = acc_cnt;
    reset = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (accept_pulse) break;
    end
    chk("hold_latency", 64'(n), 64'd7);
    repeat (15) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_once", 64'(acc_cnt - a0), 64'd1);
    q.push_back(5);
    check_state("hold_after");

    // Random single commands
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 9);
      m = (n == 0) ? 3'b100 : (n <= 2) ? 3'b010 : 3'b001;
      d = 4'($urandom_range(0, 11));
      press(m, d, "rand", 1'b1);
    end

    chk("no_overlap", 64'(both_cnt), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
